// File: rtl/jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// jk_cmd_sequencer
// Issues queued set/reset/toggle/hold commands to a master-slave JK flop stage
// and checks the flop's qn/qn_bar response against an internal model of Q.
//
// Each command: IDLE (pop) -> DRIVE (1 cycle on s/r) -> WAIT (SETTLE cycles,
// s=r=0) -> CHECK (sample qn/qn_bar, update model and counters) -> IDLE.
//
// Ports
//   clk_i         clock, all state on the rising edge
//   rst_n_i       synchronous active-low reset
//   cmd_valid_i   command present
//   cmd_i[1:0]    00 hold, 01 reset, 10 set, 11 toggle ({s,r})
//   cmd_ready_o   FIFO can accept (registered !full)
//   s_o, r_o      registered drive to the flop
//   qn_i          flop Q output
//   qn_bar_i      flop complementary output
//   busy_o        FSM not idle or FIFO not empty
//   done_o        one-cycle pulse per completed command
//   err_o         one-cycle pulse with done_o on a failed check
//   exp_q_o       model's expected Q
//   exp_known_o   model value is valid
//   cmd_cnt_o     completed commands, saturating
//   mis_cnt_o     failed checks, saturating
// -----------------------------------------------------------------------------
module jk_cmd_sequencer #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       cmd_valid_i,
   input  logic [1:0] cmd_i,
   output logic       cmd_ready_o,
   output logic       s_o,
   output logic       r_o,
   input  logic       qn_i,
   input  logic       qn_bar_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic       exp_q_o,
   output logic       exp_known_o,
   output logic [7:0] cmd_cnt_o,
   output logic [7:0] mis_cnt_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [3:0]    SETTLE_C = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      wait_cnt_q, wait_cnt_d;

   logic [1:0]      fifo_mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            cmd_ready_q;
   logic            push, pop;

   logic [1:0]      cmd_q;      // command in flight, held until CHECK
   logic [1:0]      sr_q;       // {s,r} drive register
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            exp_q_q, exp_q_d;
   logic            exp_known_q, exp_known_d;
   logic [7:0]      cmd_cnt_q, cmd_cnt_d;
   logic [7:0]      mis_cnt_q, mis_cnt_d;

   // Model value after applying cmd_q, used for both the check and the update
   logic            model_q;
   logic            model_known;
   logic            fail;

   assign push = cmd_valid_i && cmd_ready_q;
   assign pop  = (state_q == ST_IDLE) && (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage array: written on push only, no reset needed
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= cmd_i;
      end
   end

   always_comb begin
      model_q     = exp_q_q;
      model_known = exp_known_q;
      case (cmd_q)
         2'b01: begin
            model_q     = 1'b0;
            model_known = 1'b1;
         end
         2'b10: begin
            model_q     = 1'b1;
            model_known = 1'b1;
         end
         2'b11: begin
            // Toggling an unknown value leaves it unknown
            if (exp_known_q) begin
               model_q = ~exp_q_q;
            end
         end
         default: ;
      endcase
      fail = (qn_bar_i == qn_i) || (model_known && (qn_i != model_q));
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      exp_q_d     = exp_q_q;
      exp_known_d = exp_known_q;
      cmd_cnt_d   = cmd_cnt_q;
      mis_cnt_d   = mis_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            state_d    = ST_WAIT;
            wait_cnt_d = SETTLE_C;
         end
         ST_WAIT: begin
            if (wait_cnt_q == 4'd0) begin
               state_d = ST_CHECK;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         ST_CHECK: begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            // The model follows the command, not the flop, even on failure
            exp_q_d     = model_q;
            exp_known_d = model_known;
            if (cmd_cnt_q != 8'hFF) begin
               cmd_cnt_d = cmd_cnt_q + 8'd1;
            end
            if (fail) begin
               err_d = 1'b1;
               if (mis_cnt_q != 8'hFF) begin
                  mis_cnt_d = mis_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 4'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b0;
         cmd_q       <= 2'b00;
         sr_q        <= 2'b00;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         exp_q_q     <= 1'b0;
         exp_known_q <= 1'b0;
         cmd_cnt_q   <= 8'd0;
         mis_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         count_q     <= count_d;
         // Ready looks at next occupancy so a full FIFO never takes a push
         cmd_ready_q <= (count_d != DEPTH_C);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            cmd_q    <= fifo_mem[rd_ptr_q];
            sr_q     <= fifo_mem[rd_ptr_q];
         end else begin
            sr_q     <= 2'b00;
         end
         done_q      <= done_d;
         err_q       <= err_d;
         exp_q_q     <= exp_q_d;
         exp_known_q <= exp_known_d;
         cmd_cnt_q   <= cmd_cnt_d;
         mis_cnt_q   <= mis_cnt_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign s_o         = sr_q[1];
   assign r_o         = sr_q[0];
   assign busy_o      = (state_q != ST_IDLE) || (count_q != '0);
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign exp_q_o     = exp_q_q;
   assign exp_known_o = exp_known_q;
   assign cmd_cnt_o   = cmd_cnt_q;
   assign mis_cnt_o   = mis_cnt_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jk_cmd_sequencer
// Directed bench for jk_cmd_sequencer (DEPTH=4, SETTLE=1) with a behavioural
// JK flop on s/r -> qn/qn_bar and a fault override on the flop outputs.
// -----------------------------------------------------------------------------
module tb_jk_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic       cmd_ready;
   logic       s_o, r_o;
   logic       qn, qn_bar;
   logic       busy, done, err, exp_q, exp_known;
   logic [7:0] cmd_cnt, mis_cnt;

   always #5 clk = ~clk;

   jk_cmd_sequencer #(.DEPTH(4), .SETTLE(1)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_i       (cmd),
      .cmd_ready_o (cmd_ready),
      .s_o         (s_o),
      .r_o         (r_o),
      .qn_i        (qn),
      .qn_bar_i    (qn_bar),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err),
      .exp_q_o     (exp_q),
      .exp_known_o (exp_known),
      .cmd_cnt_o   (cmd_cnt),
      .mis_cnt_o   (mis_cnt)
   );

   // Behavioural flop: s/r sampled on the rising edge
   logic       q_flop = 1'b0;
   int         flt = 0;   // 0 normal, 1 qn=0/qn_bar=1, 2 qn=qn_bar=1
   always @(posedge clk) begin
      case ({s_o, r_o})
         2'b10:   q_flop <= 1'b1;
         2'b01:   q_flop <= 1'b0;
         2'b11:   q_flop <= ~q_flop;
         default: ;
      endcase
   end
   assign qn     = (flt == 1) ? 1'b0 : (flt == 2) ? 1'b1 : q_flop;
   assign qn_bar = (flt == 1) ? 1'b1 : (flt == 2) ? 1'b1 : ~q_flop;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event recorders (sampled mid-cycle)
   int   acc_cyc[$];
   int   s_cyc[$];
   int   r_cyc[$];
   int   done_cyc[$];
   logic done_err[$];
   logic done_expq[$];
   logic done_known[$];

   always @(negedge clk) begin
      if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc + 1);
      if (s_o) s_cyc.push_back(cyc);
      if (r_o) r_cyc.push_back(cyc);
      if (done) begin
         done_cyc.push_back(cyc);
         done_err.push_back(err);
         done_expq.push_back(exp_q);
         done_known.push_back(exp_known);
         $display("t=%0t done #%0d cyc=%0d err=%0b exp_q=%0b exp_known=%0b cmd_cnt=%0d mis_cnt=%0d",
                  $time, done_cyc.size(), cyc, err, exp_q, exp_known, cmd_cnt, mis_cnt);
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      acc_cyc.delete();
      s_cyc.delete();
      r_cyc.delete();
      done_cyc.delete();
      done_err.delete();
      done_expq.delete();
      done_known.delete();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      clear_log();
   endtask

   // Holds cmd_valid until the command is taken; leaves cmd_valid high
   task automatic push_one(input logic [1:0] c);
      logic rdy;
      logic taken;
      taken     = 1'b0;
      cmd       = c;
      cmd_valid = 1'b1;
      for (int g = 0; g < 60 && !taken; g++) begin
         rdy = cmd_ready;
         tick();
         if (rdy) taken = 1'b1;
      end
      if (!taken) check_val("push_timeout", 32'(taken), 32'd1);
      $display("t=%0t push cmd=%0b taken=%0b", $time, c, taken);
   endtask

   task automatic wait_done(input int n);
      for (int g = 0; g < 300 && done_cyc.size() < n; g++) tick();
      repeat (2) tick();
      check_val("done_count", 32'(done_cyc.size()), 32'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int errs;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd       = 2'b00;

      // ---- Reset values ----
      repeat (3) tick();
      check_val("rst_s", 32'(s_o), 32'd0);
      check_val("rst_r", 32'(r_o), 32'd0);
      check_val("rst_ready", 32'(cmd_ready), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      check_val("rst_expq", 32'(exp_q), 32'd0);
      check_val("rst_known", 32'(exp_known), 32'd0);
      check_val("rst_cmdcnt", 32'(cmd_cnt), 32'd0);
      check_val("rst_miscnt", 32'(mis_cnt), 32'd0);
      rst_n = 1'b1;
      tick();
      check_val("ready_after_rst", 32'(cmd_ready), 32'd1);
      clear_log();

      // ---- Set / reset pair ----
      push_one(2'b10);
      push_one(2'b01);
      cmd_valid = 1'b0;
      wait_done(2);
      check_val("sr_s_count", 32'(s_cyc.size()), 32'd1);
      check_val("sr_r_count", 32'(r_cyc.size()), 32'd1);
      if (s_cyc.size() == 1 && r_cyc.size() == 1 && acc_cyc.size() == 2 && done_cyc.size() == 2) begin
         check_val("sr_s_latency", 32'(s_cyc[0] - acc_cyc[0]), 32'd1);
         check_val("sr_r_after_s", 32'(r_cyc[0] - s_cyc[0]), 32'd4);
         check_val("sr_done_latency", 32'(done_cyc[0] - acc_cyc[0]), 32'd4);
         check_val("sr_expq0", 32'(done_expq[0]), 32'd1);
         check_val("sr_expq1", 32'(done_expq[1]), 32'd0);
         check_val("sr_err", 32'({done_err[0], done_err[1]}), 32'd0);
      end else begin
         check_val("sr_event_counts", 32'(acc_cyc.size()), 32'd2);
      end
      check_val("sr_cmdcnt", 32'(cmd_cnt), 32'd2);
      check_val("sr_miscnt", 32'(mis_cnt), 32'd0);
      check_val("sr_idle", 32'(busy), 32'd0);

      // ---- Toggle from unknown ----
      do_reset();
      push_one(2'b11);
      push_one(2'b10);
      push_one(2'b11);
      push_one(2'b11);
      cmd_valid = 1'b0;
      wait_done(4);
      if (done_cyc.size() == 4) begin
         check_val("tg_known0", 32'(done_known[0]), 32'd0);
         check_val("tg_expq1", 32'({done_known[1], done_expq[1]}), 32'b11);
         check_val("tg_expq2", 32'({done_known[2], done_expq[2]}), 32'b10);
         check_val("tg_expq3", 32'({done_known[3], done_expq[3]}), 32'b11);
         errs = 0;
         foreach (done_err[i]) errs += int'(done_err[i]);
         check_val("tg_errs", 32'(errs), 32'd0);
      end
      check_val("tg_cmdcnt", 32'(cmd_cnt), 32'd4);

      // ---- Back-pressure: 6 back-to-back with DEPTH=4 ----
      do_reset();
      begin
         logic [1:0] seq [6];
         logic       expq [6];
         seq  = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
         expq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
         for (int i = 0; i < 6; i++) begin
            push_one(seq[i]);
            if (i == 4) check_val("bp_ready_low", 32'(cmd_ready), 32'd0);
         end
         cmd_valid = 1'b0;
         wait_done(6);
         check_val("bp_accepts", 32'(acc_cyc.size()), 32'd6);
         if (done_cyc.size() == 6) begin
            for (int i = 0; i < 6; i++)
               check_val($sformatf("bp_expq%0d", i), 32'(done_expq[i]), 32'(expq[i]));
            for (int i = 1; i < 6; i++)
               check_val($sformatf("bp_gap%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'd4);
         end
      end
      check_val("bp_cmdcnt", 32'(cmd_cnt), 32'd6);

      // ---- Fault injection ----
      do_reset();
      flt = 1;
      push_one(2'b10);
      cmd_valid = 1'b0;
      wait_done(1);
      if (done_cyc.size() == 1) check_val("flt_err_set", 32'(done_err[0]), 32'd1);
      check_val("flt_miscnt1", 32'(mis_cnt), 32'd1);
      check_val("flt_expq", 32'(exp_q), 32'd1);
      flt = 2;
      push_one(2'b00);
      cmd_valid = 1'b0;
      wait_done(2);
      if (done_cyc.size() == 2) check_val("flt_err_hold", 32'(done_err[1]), 32'd1);
      check_val("flt_miscnt2", 32'(mis_cnt), 32'd2);
      check_val("flt_cmdcnt", 32'(cmd_cnt), 32'd2);
      flt = 0;

      // ---- Reset mid-operation ----
      do_reset();
      push_one(2'b10);
      push_one(2'b01);
      check_val("mid_drive_s", 32'(s_o), 32'd1);
      cmd   = 2'b11;
      rst_n = 1'b0;
      tick();
      check_val("mid_s", 32'(s_o), 32'd0);
      check_val("mid_r", 32'(r_o), 32'd0);
      check_val("mid_busy", 32'(busy), 32'd0);
      cmd_valid = 1'b0;
      rst_n     = 1'b1;
      clear_log();
      repeat (12) tick();
      check_val("mid_no_done", 32'(done_cyc.size()), 32'd0);
      check_val("mid_no_drive", 32'(s_cyc.size() + r_cyc.size()), 32'd0);
      check_val("mid_cmdcnt", 32'(cmd_cnt), 32'd0);
      check_val("mid_ready", 32'(cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Command sequencer that drives the set/reset (`s`/`r`) inputs of the master-slave JK flip-flop stage and checks the flop's `qn`/`qn_bar` response against an internal reference model. Commands arrive on a valid/ready interface into a small FIFO and are issued one at a time. Each command is held on `s`/`r` for one cycle, allowed to settle, then checked. Sits directly upstream of the flop and consumes its outputs for self-checking bring-up and regression.

## Interface
- `DEPTH`, default 4: command FIFO depth; power of two, at least 2.
- `SETTLE`, default 1: idle cycles with `s=r=0` between drive and check; range 1..15.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `cmd_valid`  in  1: command present.
- `cmd`  in  2: 00 hold, 01 reset, 10 set, 11 toggle; drives `{s,r}` directly.
- `cmd_ready`  out  1: FIFO can accept; equals `!full`, registered.
- `s`, `r`  out  1 each: drive to the flop.
- `qn`, `qn_bar`  in  1 each: flop outputs.
- `busy`  out  1: FSM not in IDLE, or FIFO not empty.
- `done`  out  1: one-cycle pulse per completed command.
- `err`  out  1: one-cycle pulse, coincident with `done`, on check failure.
- `exp_q`  out  1: model's expected Q.
- `exp_known`  out  1: model value valid.
- `cmd_cnt`  out  8: completed commands, saturating at 255.
- `mis_cnt`  out  8: failed checks, saturating at 255.

## Operation
- **FIFO:** push when `cmd_valid && cmd_ready`. Pop occurs only in IDLE when the FIFO is non-empty. A push and a pop in the same cycle are both honoured and occupancy is unchanged. Commands are never dropped.
- **FSM states:** IDLE, DRIVE, WAIT, CHECK.
  - IDLE: `s=r=0`. If the FIFO is non-empty, pop and go to DRIVE.
  - DRIVE: `{s,r}=cmd` for exactly 1 cycle, then WAIT.
  - WAIT: `s=r=0` for `SETTLE` cycles, then CHECK.
  - CHECK: sample `qn`/`qn_bar`, update the model and counters, then return to IDLE unconditionally.
- **Model update in CHECK:**
  - reset: `exp_q=0`, `exp_known=1`.
  - set: `exp_q=1`, `exp_known=1`.
  - toggle: `exp_q=~exp_q` when known; otherwise the model stays unknown.
  - hold: no change.
- **Check failure** is either of:
  - `qn_bar != ~qn`, checked on every command.
  - `exp_known` is 1 after the update and `qn != exp_q`.
- **Check outcome:**
  - On failure: `err` pulses and `mis_cnt` increments.
  - On every command: `done` pulses and `cmd_cnt` increments.
  - A failure does not alter the model; the model stays authoritative.
- **Counters** saturate at 255 and never wrap.

## Timing
- **Reset values** (every output on the edge where `rst_n=0`): `s=r=0`, `cmd_ready=0`, `busy=0`, `done=0`, `err=0`, `exp_q=0`, `exp_known=0`, `cmd_cnt=0`, `mis_cnt=0`. FIFO is empty and the FSM is in IDLE.
- `cmd_ready` rises on the first edge with `rst_n=1`.
- **Reset mid-operation:** any in-flight command and all queued commands are discarded. `s`/`r` return to 0 on that same edge. No `done` pulse is produced for the aborted command.
- **Command latency:** command accepted at edge k. `s`/`r` are valid from edge k+1 through edge k+2. `done`/`err` are high for the cycle following edge k+2+`SETTLE`+1.
- **Throughput:** one command per `SETTLE`+3 cycles, i.e. 4 cycles at default settings.
- **Back-pressure:** after `DEPTH` accepted commands while the FSM is busy, `cmd_ready` is 0 from the next edge. It returns to 1 the edge after a pop.
- **Registered outputs:** `s`, `r`, `done`, `err` and the counters are all registered; there is no combinational path from `qn`/`qn_bar` to any output.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles, then release. All outputs read 0; `cmd_ready`=1 one cycle after release.
- **Set/reset pair:** push set, then reset, with a correct flop model connected.
  - `s=1,r=0` for one cycle, then `s=0,r=1` four cycles later.
  - `exp_q` reads 1, then 0.
  - `cmd_cnt`=2, `mis_cnt`=0, no `err`.
- **Toggle and unknown state:** push toggle, then set, toggle, toggle.
  - The first toggle leaves `exp_known=0` and produces no value check.
  - After the full sequence `exp_q` reads 1→0→1.
  - `cmd_cnt`=4.
- **Back-pressure:** push 6 commands back-to-back with `DEPTH`=4.
  - `cmd_ready` drops after the 5th acceptance: 1 command popped, 4 queued.
  - All 6 commands complete in order.
  - `done` pulses are 4 cycles apart.
- **Fault injection:** bench forces `qn` stuck at 0, `qn_bar`=1. Push set.
  - `err` and `done` pulse together.
  - `mis_cnt`=1 and `exp_q` stays 1.
  - Separately, force `qn=qn_bar=1`: `err` pulses even on a hold command.
- **Reset mid-operation:** push 3 commands and assert `rst_n=0` during the DRIVE of the first. `s`/`r` go to 0 on that edge, no `done` is produced, and the FIFO is empty after reset release.
